// File: rtl/prio_int_ctrl_pkg.sv
// Shared constants for the priority interrupt controller: register offsets, FSM states, source limit.
// Pure declarations; no logic, no latency.
package prio_int_pkg;

    localparam int MAX_SRC  = 16;
    localparam int NUM_REGS = 6;

    localparam logic [2:0] REG_PEND  = 3'd0;
    localparam logic [2:0] REG_MASK  = 3'd1;
    localparam logic [2:0] REG_MODE  = 3'd2;
    localparam logic [2:0] REG_EOI   = 3'd3;
    localparam logic [2:0] REG_VBASE = 3'd4;
    localparam logic [2:0] REG_STAT  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELIVER = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/prio_int_ctrl_if.sv
// CPU-side bundle: shared mm_* register bus plus interrupt delivery (int_occurred/int_vec, stall_IM_ID).
// master = cpu/bus driver, slave = interrupt controller.
interface prio_int_ctrl_if;
    logic [15:0] mm_addr;
    logic        mm_we;
    logic        mm_re;
    logic [15:0] mm_wdata;
    logic [15:0] mm_rdata;
    logic        stall_IM_ID;
    logic        int_occurred;
    logic [15:0] int_vec;

    modport master (
        output mm_addr, mm_we, mm_re, mm_wdata, stall_IM_ID,
        input  mm_rdata, int_occurred, int_vec
    );

    modport slave (
        input  mm_addr, mm_we, mm_re, mm_wdata, stall_IM_ID,
        output mm_rdata, int_occurred, int_vec
    );
endinterface

// File: rtl/prio_int_ctrl_int_prio_enc.sv
// Lowest-index-first priority encoder; purely combinational, zero latency, no backpressure.
module int_prio_enc #(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] i_req,
    output logic               o_vld,
    output logic [3:0]         o_id
);

    // Scan from the top down so the lowest set index is the last (winning) assignment.
    always_comb begin
        o_vld = 1'b0;
        o_id  = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_vld = 1'b1;
                o_id  = i[3:0];
            end
        end
    end

endmodule

// File: rtl/prio_int_ctrl.sv
// Memory-mapped fixed-priority interrupt controller: PEND/MASK/MODE/EOI/VBASE/STAT, IDLE->DELIVER->SERVICE.
// Request reaches DELIVER one edge after PEND sets; DELIVER holds id/vec while stall_IM_ID is high.
module prio_int_ctrl
    import prio_int_pkg::*;
#(
    parameter int          NUM_SRC      = 8,
    parameter logic [15:0] ADDR_BASE    = 16'hC010,
    parameter logic [15:0] VEC_BASE_RST = 16'h0010
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_SRC-1:0] i_int_src,
    prio_int_ctrl_if.slave     bus
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [NUM_SRC-1:0]  r_src_q;
    logic [NUM_SRC-1:0]  r_pend;
    logic [NUM_SRC-1:0]  r_mask;
    logic [NUM_SRC-1:0]  r_mode;
    logic [15:0]         r_vbase;
    logic [3:0]          r_id;
    logic [15:0]         r_vec;

    logic [15:0]         w_off;
    logic                w_in_win;
    logic                w_wr_pend, w_wr_mask, w_wr_mode, w_wr_eoi, w_wr_vbase;
    logic [NUM_SRC-1:0]  w_wdat;
    logic [NUM_SRC-1:0]  w_mode_nxt;
    logic [NUM_SRC-1:0]  w_edge;
    logic [NUM_SRC-1:0]  w_w1c;
    logic [NUM_SRC-1:0]  w_id_oh;
    logic [NUM_SRC-1:0]  w_dlv_clr;
    logic [NUM_SRC-1:0]  w_pend_nxt;
    logic [NUM_SRC-1:0]  w_pend_view;
    logic [NUM_SRC-1:0]  w_elig;
    logic                w_enc_vld;
    logic [3:0]          w_enc_id;
    logic                w_deliver_done;
    logic [MAX_SRC-1:0]  w_pend16, w_mask16, w_mode16;
    logic [15:0]         w_stat;
    logic [15:0]         w_rdata;

    assign w_off      = bus.mm_addr - ADDR_BASE;
    assign w_in_win   = (w_off < 16'(NUM_REGS));
    assign w_wr_pend  = bus.mm_we && w_in_win && (w_off[2:0] == REG_PEND);
    assign w_wr_mask  = bus.mm_we && w_in_win && (w_off[2:0] == REG_MASK);
    assign w_wr_mode  = bus.mm_we && w_in_win && (w_off[2:0] == REG_MODE);
    assign w_wr_eoi   = bus.mm_we && w_in_win && (w_off[2:0] == REG_EOI);
    assign w_wr_vbase = bus.mm_we && w_in_win && (w_off[2:0] == REG_VBASE);
    assign w_wdat     = bus.mm_wdata[NUM_SRC-1:0];

    always_comb begin
        w_id_oh = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_id_oh[i] = (r_id == i[3:0]);
        end
    end

    assign w_deliver_done = (r_state == ST_DELIVER) && !bus.stall_IM_ID;
    assign w_dlv_clr      = w_deliver_done ? w_id_oh : '0;
    assign w_w1c          = w_wr_pend ? w_wdat : '0;
    assign w_edge         = i_int_src & ~r_src_q;
    assign w_mode_nxt     = w_wr_mode ? w_wdat : r_mode;
    // Edge set wins over clears; bits switching to level mode lose any latched edge.
    assign w_pend_nxt     = w_mode_nxt & (w_edge | (r_pend & ~w_w1c & ~w_dlv_clr));
    assign w_pend_view    = r_pend | (~r_mode & r_src_q);
    assign w_elig         = w_pend_view & r_mask;

    int_prio_enc #(.NUM_SRC(NUM_SRC)) u_enc (
        .i_req (w_elig),
        .o_vld (w_enc_vld),
        .o_id  (w_enc_id)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_src_q <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_mode  <= '1;
            r_vbase <= VEC_BASE_RST;
            r_id    <= 4'd0;
            r_vec   <= 16'h0000;
        end else begin
            r_src_q <= i_int_src;
            r_pend  <= w_pend_nxt;
            r_mode  <= w_mode_nxt;
            if (w_wr_mask)  r_mask  <= w_wdat;
            if (w_wr_vbase) r_vbase <= bus.mm_wdata;
            if (r_state == ST_IDLE && w_enc_vld) begin
                r_id  <= w_enc_id;
                r_vec <= r_vbase + {12'd0, w_enc_id};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_enc_vld)      w_state_nxt = ST_DELIVER;
            ST_DELIVER: if (w_deliver_done) w_state_nxt = ST_SERVICE;
            ST_SERVICE: if (w_wr_eoi)       w_state_nxt = ST_IDLE;
            default:                        w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.int_occurred = (r_state == ST_DELIVER);
        bus.int_vec      = r_vec;
    end

    always_comb begin
        w_stat = 16'h0000;
        if (r_state == ST_SERVICE) w_stat[15] = 1'b1;
        if (r_state != ST_IDLE)    w_stat[3:0] = r_id;
    end

    always_comb begin
        w_pend16 = '0;
        w_mask16 = '0;
        w_mode16 = '0;
        w_pend16[NUM_SRC-1:0] = w_pend_view;
        w_mask16[NUM_SRC-1:0] = r_mask;
        w_mode16[NUM_SRC-1:0] = r_mode;
        w_rdata = 16'h0000;
        if (bus.mm_re && w_in_win) begin
            case (w_off[2:0])
                REG_PEND:  w_rdata = w_pend16;
                REG_MASK:  w_rdata = w_mask16;
                REG_MODE:  w_rdata = w_mode16;
                REG_VBASE: w_rdata = r_vbase;
                REG_STAT:  w_rdata = w_stat;
                default:   w_rdata = 16'h0000;
            endcase
        end
    end

    assign bus.mm_rdata = w_rdata;

endmodule

// File: tb/tb_prio_int_ctrl.sv
// Directed bench for prio_int_ctrl: register reset values, priority, stall hold, level mode, W1C precedence.
module tb_prio_int_ctrl;

    localparam logic [15:0] BASE = 16'hC010;

    logic       clk;
    logic       rst_n;
    logic [7:0] int_src;
    int         n_checks;
    int         n_errors;

    prio_int_ctrl_if bus_if ();

    prio_int_ctrl #(
        .NUM_SRC      (8),
        .ADDR_BASE    (16'hC010),
        .VEC_BASE_RST (16'h0010)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_int_src (int_src),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [15:0] obs, input logic [15:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] off, input logic [15:0] dat);
        bus_if.mm_addr  = BASE + {13'd0, off};
        bus_if.mm_wdata = dat;
        bus_if.mm_we    = 1'b1;
        step(1);
        bus_if.mm_we    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] off, input logic [15:0] exp, input string tag);
        bus_if.mm_addr = BASE + {13'd0, off};
        bus_if.mm_re   = 1'b1;
        #1;
        chk(bus_if.mm_rdata, exp, tag);
        bus_if.mm_re   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        int_src = 8'h00;
        bus_if.mm_addr = 16'h0000;
        bus_if.mm_we = 1'b0;
        bus_if.mm_re = 1'b0;
        bus_if.mm_wdata = 16'h0000;
        bus_if.stall_IM_ID = 1'b0;
        step(2);
        rst_n = 1'b1;

        // Reset state
        chk({15'd0, bus_if.int_occurred}, 16'h0000, "rst_occ");
        chk(bus_if.int_vec, 16'h0000, "rst_vec");
        chk(bus_if.mm_rdata, 16'h0000, "rst_rdata_nostrobe");
        rd(3'd0, 16'h0000, "rst_pend");
        rd(3'd1, 16'h0000, "rst_mask");
        rd(3'd2, 16'h00FF, "rst_mode");
        rd(3'd3, 16'h0000, "rst_eoi");
        rd(3'd4, 16'h0010, "rst_vbase");
        rd(3'd5, 16'h0000, "rst_stat");
        rd(3'd6, 16'h0000, "out_of_window");

        // Single edge on source 2
        wr(3'd1, 16'h0005);
        int_src = 8'h04;
        step(1);
        int_src = 8'h00;
        chk({15'd0, bus_if.int_occurred}, 16'h0000, "e2_not_yet");
        rd(3'd0, 16'h0004, "e2_pend_set");
        step(1);
        chk({15'd0, bus_if.int_occurred}, 16'h0001, "e2_occ");
        chk(bus_if.int_vec, 16'h0012, "e2_vec");
        step(1);
        chk({15'd0, bus_if.int_occurred}, 16'h0000, "e2_occ_drop");
        rd(3'd0, 16'h0000, "e2_pend_clr");
        rd(3'd5, 16'h8002, "e2_stat");
        wr(3'd3, 16'h0000);
        rd(3'd5, 16'h0000, "e2_stat_eoi");

        // Sources 0 and 2 together: 0 wins, 2 follows after EOI
        int_src = 8'h05;
        step(1);
        int_src = 8'h00;
        rd(3'd0, 16'h0005, "pr_pend_both");
        step(1);
        chk(bus_if.int_vec, 16'h0010, "pr_vec_first");
        step(1);
        rd(3'd0, 16'h0004, "pr_pend_left");
        wr(3'd3, 16'h0000);
        chk({15'd0, bus_if.int_occurred}, 16'h0000, "pr_idle_after_eoi");
        step(1);
        chk({15'd0, bus_if.int_occurred}, 16'h0001, "pr_occ_second");
        chk(bus_if.int_vec, 16'h0012, "pr_vec_second");
        step(1);
        wr(3'd3, 16'h0000);

        // Stall held during DELIVER
        bus_if.stall_IM_ID = 1'b1;
        int_src = 8'h01;
        step(1);
        int_src = 8'h00;
        step(1);
        for (int i = 0; i < 5; i++) begin
            chk({15'd0, bus_if.int_occurred}, 16'h0001, "st_occ_stalled");
            chk(bus_if.int_vec, 16'h0010, "st_vec_stalled");
            rd(3'd0, 16'h0001, "st_pend_held");
            step(1);
        end
        bus_if.stall_IM_ID = 1'b0;
        chk({15'd0, bus_if.int_occurred}, 16'h0001, "st_occ_unstalled");
        step(1);
        chk({15'd0, bus_if.int_occurred}, 16'h0000, "st_occ_exit");
        rd(3'd0, 16'h0000, "st_pend_clr");
        wr(3'd3, 16'h0000);

        // Level mode on source 1
        wr(3'd2, 16'h00FD);
        wr(3'd1, 16'h0002);
        int_src = 8'h02;
        step(1);
        rd(3'd0, 16'h0002, "lv_pend_live");
        step(1);
        chk({15'd0, bus_if.int_occurred}, 16'h0001, "lv_occ");
        chk(bus_if.int_vec, 16'h0011, "lv_vec");
        step(1);
        wr(3'd0, 16'h0002);
        rd(3'd0, 16'h0002, "lv_w1c_ignored");
        wr(3'd3, 16'h0000);
        step(1);
        chk({15'd0, bus_if.int_occurred}, 16'h0001, "lv_redeliver");
        step(1);
        int_src = 8'h00;
        step(1);
        rd(3'd0, 16'h0000, "lv_pend_drop");
        wr(3'd3, 16'h0000);
        step(2);
        chk({15'd0, bus_if.int_occurred}, 16'h0000, "lv_no_delivery");

        // Masked source still latches, W1C clears it
        wr(3'd2, 16'h00FF);
        wr(3'd1, 16'h0000);
        int_src = 8'h10;
        step(1);
        int_src = 8'h00;
        rd(3'd0, 16'h0010, "mk_latched");
        step(1);
        chk({15'd0, bus_if.int_occurred}, 16'h0000, "mk_no_delivery");
        wr(3'd0, 16'h0010);
        rd(3'd0, 16'h0000, "mk_w1c");

        // Edge beats same-cycle W1C; new vector base
        wr(3'd4, 16'h0100);
        wr(3'd1, 16'h0008);
        int_src = 8'h08;
        bus_if.mm_addr = BASE;
        bus_if.mm_wdata = 16'h0008;
        bus_if.mm_we = 1'b1;
        step(1);
        bus_if.mm_we = 1'b0;
        int_src = 8'h00;
        rd(3'd0, 16'h0008, "w1c_edge_wins");
        step(1);
        chk(bus_if.int_vec, 16'h0103, "vb_vec");
        step(1);
        rd(3'd5, 16'h8003, "vb_stat");
        wr(3'd3, 16'h0000);
        rd(3'd5, 16'h0000, "vb_stat_eoi");

        // Reset during DELIVER
        int_src = 8'h08;
        step(1);
        int_src = 8'h00;
        step(1);
        chk({15'd0, bus_if.int_occurred}, 16'h0001, "mr_occ_before");
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk({15'd0, bus_if.int_occurred}, 16'h0000, "mr_occ");
        chk(bus_if.int_vec, 16'h0000, "mr_vec");
        rd(3'd0, 16'h0000, "mr_pend");
        rd(3'd1, 16'h0000, "mr_mask");
        rd(3'd4, 16'h0010, "mr_vbase");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prio_int_ctrl.md
# prio_int_ctrl

Parametrised memory-mapped interrupt controller that generalises the 4-source controller to NUM_SRC sources, adding per-source enable masking, per-source edge/level mode, fixed priority arbitration, a programmable vector base and explicit end-of-interrupt handshaking. It sits beside the cpu on the shared mm_* bus, takes raw interrupt sources from peripherals (timer overflow, FFT buffer valid, etc.) and presents int_occurred/int_vec to the cpu, respecting stall_IM_ID.

## Interface
- NUM_SRC, 8: number of interrupt sources, 1..16.
- ADDR_BASE, 16'hC010: base address of the 6-word register window.
- VEC_BASE_RST, 16'h0010: reset value of the vector-base register.

- clk  input  1  system clock.
- rst_n  input  1  reset; one clock, reset is synchronous and active-low.
- int_src  input  NUM_SRC  raw interrupt requests, synchronous to clk.
- stall_IM_ID  input  1  cpu IM/ID stall; delivery completes only when low.
- mm_addr  input  16  bus address.
- mm_we  input  1  bus write strobe.
- mm_re  input  1  bus read strobe.
- mm_wdata  input  16  bus write data.
- mm_rdata  output  16  read data; 16'h0000 when not selected (OR-able).
- int_occurred  output  1  interrupt request to cpu.
- int_vec  output  16  vector address of delivered interrupt.

## Operation
- Registers (offset from ADDR_BASE; bits above NUM_SRC read 0, ignore writes):
  - +0 PEND: edge bits W1C; level bits read live, writes ignored. Reset 0.
  - +1 MASK: RW, 1 = enabled. Reset 0.
  - +2 MODE: RW, 1 = edge, 0 = level. Reset all ones.
  - +3 EOI: any write ends service; reads 0.
  - +4 VBASE: RW. Reset VEC_BASE_RST.
  - +5 STAT: RO, bit15 = in service, bits3:0 = active id.
- Edge source i: PEND[i] set on clk edge where int_src[i]=1 and src_q[i]=0 (src_q = previous-cycle sample, reset 0). Masked sources still latch.
- Level source i: PEND[i] = src_q[i].
- Eligible = PEND & MASK; winner = lowest set index.
- FSM IDLE / DELIVER / SERVICE, reset IDLE:
  - IDLE: if eligible != 0, latch id, int_vec <= VBASE + id, go DELIVER.
  - DELIVER: int_occurred = 1. On first cycle with stall_IM_ID = 0: clear PEND[id] if edge mode, go SERVICE. While stall high: stay, hold id/vec.
  - SERVICE: int_occurred = 0; on EOI write go IDLE. No new delivery in SERVICE (no nesting).
- Precedence: new edge set beats W1C or delivery-clear in the same cycle (bit stays 1). EOI write in IDLE/DELIVER ignored. MASK/MODE/VBASE writes during DELIVER/SERVICE do not alter latched id/vec. MODE change edge->level drops latched edge bit.
- mm_rdata combinational: selected register when mm_re and mm_addr in window, else 0. Writes take effect at clock edge with mm_we.
- Reset mid-operation: all state to reset values next edge; pending interrupts lost.

## Timing
- Reset values: int_occurred 0, int_vec 16'h0000, mm_rdata 0 (combinational, no strobe).
- Edge latency: int_src rises before edge k -> PEND set at k -> DELIVER (int_occurred=1) after edge k+1 -> SERVICE after first edge with stall low.
- Level latency: src_q at k, same remainder.
- int_occurred high ≥1 cycle, stable with int_vec until DELIVER exit.
- EOI at edge m -> IDLE at m; next delivery earliest after edge m+1.

## Structure
- Package prio_int_pkg: register offset constants (PEND..STAT), FSM state enum, MAX_SRC = 16.
- Sub-module int_prio_enc (NUM_SRC parameter): combinational lowest-index-first encoder, outputs valid + 4-bit id. Top holds registers, edge detect, FSM and read mux.

## Test plan
- Reset, read all 6 registers -> PEND 0, MASK 0, MODE 16'h00FF, VBASE 16'h0010, STAT 0; int_occurred 0.
- MASK=0x0005, pulse int_src[2] one cycle, stall low -> int_occurred 1 cycle, int_vec 16'h0012, PEND[2] cleared, STAT 16'h8002; EOI -> STAT 0.
- Sources 2 and 0 rise same cycle, MASK=0x0005 -> vector 0x0010 first; after EOI vector 0x0012 delivered.
- stall_IM_ID held high 5 cycles during DELIVER -> int_occurred high all 5 plus first unstalled cycle, int_vec constant, PEND not cleared until exit.
- MODE[1]=0 (level), hold int_src[1] high, MASK=0x0002 -> delivered; W1C to PEND[1] no effect; after EOI, still high -> redelivered; drop input -> PEND[1] 0, no delivery.
- Edge on source 3 same cycle as W1C of PEND[3] -> PEND[3] remains 1; VBASE=0x0100 -> vector 0x0103.
